// File: rtl/passenger_queue_scheduler_if.sv
// Handshake/status bundle between the passenger queue scheduler and the
// screening lane; master drives arrivals and lane_ready, slave is the scheduler.
interface passenger_queue_scheduler_if #(
    parameter int CNT_W = 4
);
    logic [2:0]         arrive;
    logic               lane_ready;
    logic               grant_valid;
    logic [1:0]         class_sel;
    logic [2:0]         pending;
    logic [3*CNT_W-1:0] q_count;
    logic [2:0]         overflow;

    modport master (
        output arrive, lane_ready,
        input  grant_valid, class_sel, pending, q_count, overflow
    );

    modport slave (
        input  arrive, lane_ready,
        output grant_valid, class_sel, pending, q_count, overflow
    );
endinterface

// File: rtl/passenger_queue_scheduler.sv
// Per-class passenger counters with fixed-priority (VIP > Business > Regular)
// valid/ready offer FSM. Define AGING_EN to add Regular anti-starvation aging.
module passenger_queue_scheduler #(
    parameter int CNT_W     = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    passenger_queue_scheduler_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [1:0]              class_sel_q, class_sel_d;
    logic [2:0][CNT_W-1:0]   count_q, count_d;
    logic [2:0]              pending_q, pending_d;
    logic [2:0]              overflow_q, overflow_d;
    logic                    accept_s;
    logic [2:0]              dec_s;
    logic [1:0]              next_class_s;

    function automatic logic [1:0] pick_class(input logic [2:0] pend);
        if (pend[2]) begin
            return 2'b10;
        end else if (pend[1]) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign accept_s = grant_valid_q && bus.lane_ready;

    // Counter update: arrival and accept on the same class cancel, full counters drop arrivals
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        dec_s      = 3'b000;
        pending_d  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            dec_s[i] = accept_s && (class_sel_q == 2'(i));
            if (bus.arrive[i] && !dec_s[i]) begin
                if (count_q[i] == CNT_MAX) begin
                    overflow_d[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + CNT_ONE;
                end
            end else if (dec_s[i] && !bus.arrive[i]) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end else begin
                count_d[i] = count_q[i];
            end
            pending_d[i] = (count_d[i] != CNT_ZERO);
        end
    end

`ifdef AGING_EN
    localparam logic [7:0] AGE_LIM = 8'(AGE_LIMIT);

    logic [7:0] age_q, age_d;

    // Age tracks Business/VIP grants served while Regular waits
    always_comb begin
        if (!pending_q[0]) begin
            age_d = 8'd0;
        end else if (accept_s && (class_sel_q == 2'b00)) begin
            age_d = 8'd0;
        end else if (accept_s && (age_q != 8'hFF)) begin
            age_d = age_q + 8'd1;
        end else begin
            age_d = age_q;
        end
        if (pending_q[0] && (age_q >= AGE_LIM)) begin
            next_class_s = 2'b00;
        end else begin
            next_class_s = pick_class(pending_q);
        end
    end

    // Age register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 8'd0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic [7:0] unused_age_limit_s;

    assign unused_age_limit_s = 8'(AGE_LIMIT);
    assign next_class_s       = pick_class(pending_q);
`endif

    // Offer FSM: class_sel is latched on entry to OFFER and held until accepted
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        class_sel_d   = class_sel_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 3'b000) begin
                    class_sel_d   = next_class_s;
                    grant_valid_d = 1'b1;
                    state_d       = OFFER;
                end else begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            OFFER: begin
                if (bus.lane_ready) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    grant_valid_d = 1'b1;
                    state_d       = OFFER;
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    // State, counters and all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            class_sel_q   <= 2'b00;
            count_q       <= {3{CNT_ZERO}};
            pending_q     <= 3'b000;
            overflow_q    <= 3'b000;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            class_sel_q   <= class_sel_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.grant_valid = grant_valid_q;
    assign bus.class_sel   = class_sel_q;
    assign bus.pending     = pending_q;
    assign bus.q_count     = count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_passenger_queue_scheduler.sv
// Directed table-driven bench for passenger_queue_scheduler (CNT_W=4, AGE_LIMIT=2),
// with hand-written sequences for overflow, async reset and aging/starvation.
module tb_passenger_queue_scheduler;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    passenger_queue_scheduler_if #(.CNT_W(4)) bus_if ();

    passenger_queue_scheduler #(.CNT_W(4), .AGE_LIMIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct {
        logic [2:0]  arrive;
        logic        ready;
        logic        gv;
        logic [1:0]  sel;
        logic [2:0]  pend;
        logic [11:0] qcnt;
    } vec_t;

    vec_t vecs[23];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] grants[4];
        logic [1:0] exp_g[4];
        int         got;

        // inputs applied before an edge, outputs expected after that edge
        vecs[0]  = '{3'b001, 1'b1, 1'b0, 2'b00, 3'b001, 12'h001};
        vecs[1]  = '{3'b000, 1'b1, 1'b1, 2'b00, 3'b001, 12'h001};
        vecs[2]  = '{3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 12'h000};
        vecs[3]  = '{3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 12'h000};
        vecs[4]  = '{3'b111, 1'b1, 1'b0, 2'b00, 3'b111, 12'h111};
        vecs[5]  = '{3'b000, 1'b1, 1'b1, 2'b10, 3'b111, 12'h111};
        vecs[6]  = '{3'b000, 1'b1, 1'b0, 2'b10, 3'b011, 12'h011};
        vecs[7]  = '{3'b000, 1'b1, 1'b1, 2'b01, 3'b011, 12'h011};
        vecs[8]  = '{3'b000, 1'b1, 1'b0, 2'b01, 3'b001, 12'h001};
        vecs[9]  = '{3'b000, 1'b1, 1'b1, 2'b00, 3'b001, 12'h001};
        vecs[10] = '{3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 12'h000};
        vecs[11] = '{3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 12'h000};
        vecs[12] = '{3'b010, 1'b0, 1'b0, 2'b00, 3'b010, 12'h010};
        vecs[13] = '{3'b000, 1'b0, 1'b1, 2'b01, 3'b010, 12'h010};
        vecs[14] = '{3'b100, 1'b0, 1'b1, 2'b01, 3'b110, 12'h110};
        vecs[15] = '{3'b000, 1'b0, 1'b1, 2'b01, 3'b110, 12'h110};
        vecs[16] = '{3'b000, 1'b0, 1'b1, 2'b01, 3'b110, 12'h110};
        vecs[17] = '{3'b000, 1'b0, 1'b1, 2'b01, 3'b110, 12'h110};
        vecs[18] = '{3'b000, 1'b0, 1'b1, 2'b01, 3'b110, 12'h110};
        vecs[19] = '{3'b000, 1'b1, 1'b0, 2'b01, 3'b100, 12'h100};
        vecs[20] = '{3'b000, 1'b1, 1'b1, 2'b10, 3'b100, 12'h100};
        vecs[21] = '{3'b000, 1'b1, 1'b0, 2'b10, 3'b000, 12'h000};
        vecs[22] = '{3'b000, 1'b0, 1'b0, 2'b10, 3'b000, 12'h000};

        rst_n             = 1'b0;
        bus_if.arrive     = 3'b000;
        bus_if.lane_ready = 1'b0;
        #12;
        check("rst_gv",   12'(bus_if.grant_valid), 12'h000);
        check("rst_sel",  12'(bus_if.class_sel),   12'h000);
        check("rst_pend", 12'(bus_if.pending),     12'h000);
        check("rst_qcnt", bus_if.q_count,          12'h000);
        check("rst_ovf",  12'(bus_if.overflow),    12'h000);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 23; v++) begin
            bus_if.arrive     = vecs[v].arrive;
            bus_if.lane_ready = vecs[v].ready;
            step();
            check($sformatf("v%0d_gv", v),   12'(bus_if.grant_valid), 12'(vecs[v].gv));
            check($sformatf("v%0d_sel", v),  12'(bus_if.class_sel),   12'(vecs[v].sel));
            check($sformatf("v%0d_pend", v), 12'(bus_if.pending),     12'(vecs[v].pend));
            check($sformatf("v%0d_qcnt", v), bus_if.q_count,          vecs[v].qcnt);
        end
        bus_if.arrive = 3'b000;

        // saturate Regular while the lane stalls
        bus_if.arrive     = 3'b001;
        bus_if.lane_ready = 1'b0;
        for (int k = 0; k < 15; k++) step();
        check("sat15_qcnt", bus_if.q_count,       12'h00F);
        check("sat15_ovf",  12'(bus_if.overflow), 12'h000);
        step();
        check("sat16_qcnt", bus_if.q_count,       12'h00F);
        check("sat16_ovf",  12'(bus_if.overflow), 12'h001);
        check("sat16_gv",   12'(bus_if.grant_valid), 12'h001);
        bus_if.lane_ready = 1'b1;
        step();
        check("full_cancel_qcnt", bus_if.q_count,          12'h00F);
        check("full_cancel_ovf",  12'(bus_if.overflow),    12'h001);
        check("full_cancel_gv",   12'(bus_if.grant_valid), 12'h000);
        bus_if.arrive     = 3'b000;
        bus_if.lane_ready = 1'b0;
        step();
        check("reoffer_gv",  12'(bus_if.grant_valid), 12'h001);
        check("reoffer_sel", 12'(bus_if.class_sel),   12'h000);

        // asynchronous reset mid-offer, checked between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gv",   12'(bus_if.grant_valid), 12'h000);
        check("arst_pend", 12'(bus_if.pending),     12'h000);
        check("arst_qcnt", bus_if.q_count,          12'h000);
        check("arst_ovf",  12'(bus_if.overflow),    12'h000);
        #2;
        rst_n = 1'b1;
        step();

        // one Regular behind four VIPs
        bus_if.arrive = 3'b101;
        step();
        bus_if.arrive = 3'b100;
        for (int k = 0; k < 3; k++) step();
        bus_if.arrive     = 3'b000;
        bus_if.lane_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            if (bus_if.grant_valid) begin
                grants[got] = bus_if.class_sel;
                got++;
            end
            step();
        end
`ifdef AGING_EN
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b00; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
        check("grant_count", 12'(got), 12'd4);
        for (int g = 0; g < got; g++) begin
            check($sformatf("grant%0d_sel", g), 12'(grants[g]), 12'(exp_g[g]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/passenger_queue_scheduler.md
# passenger_queue_scheduler

Upstream stage of the lane priority checker. The block counts waiting passengers per class (Regular, Business, VIP) and publishes per-class pending flags in the checker's `priority_in` bit order. It also selects the next class to screen and offers it to the lane with a valid/ready handshake, driving the checker's 2-bit class select.

## Interface
- `CNT_W`, default 4: per-class queue counter width; each counter holds a maximum of 2^CNT_W-1 passengers.
- `AGE_LIMIT`, default 8: consecutive non-Regular grants allowed while Regular is waiting (used only when `AGING_EN` is defined); legal range 1..255.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `arrive`  in  3: one-cycle arrival pulses; [0]=Regular, [1]=Business, [2]=VIP; any combination may be set in the same cycle.
- `lane_ready`  in  1: the screening lane accepts the offered passenger.
- `grant_valid`  out  1: a passenger of class `class_sel` is being offered (registered).
- `class_sel`  out  2: 00=Regular, 01=Business, 10=VIP; 11 is never driven.
- `pending`  out  3: bit i = (count_i != 0), bit order as `arrive`; feeds the checker's `priority_in`.
- `q_count`  out  3*CNT_W: packed counts; [CNT_W-1:0] is Regular, then Business, then VIP.
- `overflow`  out  3: sticky per-class flag, set when an arrival is dropped because the counter was full.

## Operation
- Reset values: all counts 0, `grant_valid`=0, `class_sel`=00, `pending`=000, `overflow`=000, FSM in IDLE, age counter 0.
- Counters:
  - On an `arrive[i]` pulse, count_i increments.
  - If count_i is at its maximum, the arrival is dropped, the count stays at its maximum, and `overflow[i]` is set.
  - `overflow` bits clear only on reset.
- Accepted grant: `grant_valid` && `lane_ready` decrements the count of the offered class.
- Same-cycle arrival and accepted grant on the same class: the count is unchanged. This also applies when the counter is full; no overflow is flagged in that case.
- FSM has two states:
  - IDLE: `grant_valid`=0. If `pending` != 0, latch the selected class into `class_sel` and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `grant_valid`=1, and `class_sel` holds stable regardless of new arrivals. On `lane_ready`, complete the handshake and return to IDLE. Otherwise stay in OFFER indefinitely.
- Selection is a fixed priority: VIP > Business > Regular, among the pending classes only.
- `lane_ready` while `grant_valid`=0 has no effect.

## Timing
- Counts and `pending` are registered. An arrival at edge k is visible on `pending`/`q_count` after edge k.
- Starting from IDLE, an arrival at edge k produces `grant_valid`=1 after edge k+1 (2-cycle latency).
- The handshake completes at the edge where `grant_valid` && `lane_ready`. `grant_valid` drops after that edge, with one mandatory IDLE bubble. Maximum throughput is 1 grant per 2 cycles.
- `pending` reflects post-decrement counts after the accept edge.
- Asserting `rst_n` mid-offer clears everything immediately (asynchronously). The in-flight offer is lost; it is not counted as served.

## Configuration
- `AGING_EN` defined:
  - An 8-bit age counter increments on each accepted grant to Business or VIP made while Regular is pending.
  - The counter clears on any accepted Regular grant and whenever Regular is not pending.
  - When age >= `AGE_LIMIT` and Regular is pending, the next IDLE selection is forced to Regular, overriding VIP and Business.
- `AGING_EN` undefined: no age counter; strict fixed priority only. Regular may starve.

## Test plan
- Reset, then pulse `arrive`=001 once: `pending`=001 after 1 cycle; `grant_valid`=1 with `class_sel`=00 one cycle later. Hold `lane_ready`=1: count goes to 0, `pending`=000, `grant_valid`=0 next cycle.
- `arrive`=111 in one cycle with `lane_ready`=1 held: grants in order 10, 01, 00, each 2 cycles apart; final `q_count`=0.
- Offer Business with `lane_ready`=0 for 5 cycles while VIP arrives: `class_sel` stays 01. After `lane_ready`, the next grant is 10.
- Pulse Regular 16 times with CNT_W=4: `q_count` Regular field = 15 and `overflow`=001. Then arrival plus accept on Regular in the same cycle: count stays 15, `overflow` is still 001.
- With `AGING_EN` and AGE_LIMIT=2: keep VIP continuously pending and one Regular waiting. Expected grants: 10, 10, then 00, then 10 resumes.
- Assert `rst_n`=0 during OFFER: `grant_valid`, `pending`, `q_count`, and `overflow` go to 0 immediately, with no clock edge required.
